// File: rtl/breakout_game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// breakout_game_ctrl_pkg : shared game state codes and playfield constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package breakout_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT  = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_GAMEOVER = 3'd3
  } game_state_e;

  localparam int BRICKS_H        = 16;
  localparam int BRICKS_V        = 8;
  localparam int BRICK_COUNT_DEF = BRICKS_H * BRICKS_V;
  localparam int TIMER_W         = 8;

  function automatic logic bcd_is_max(input logic [3:0] d1, input logic [3:0] d0);
    return (d1 == 4'd9) && (d0 == 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/breakout_game_ctrl_score.sv
// ---------------------------------------------------------------------------
// bcd_score_counter : two-digit BCD counter with clear, increment, 99 ceiling
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_score_counter
  import breakout_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit0,
  output logic [3:0] digit1
);

  logic [3:0] d0_q, d0_d;
  logic [3:0] d1_q, d1_d;

  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    if (clr) begin
      d0_d = 4'd0;
      d1_d = 4'd0;
    end else if (inc && !bcd_is_max(d1_q, d0_q)) begin
      if (d0_q == 4'd9) begin
        d0_d = 4'd0;
        d1_d = d1_q + 4'd1;
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_q <= 4'd0;
      d1_q <= 4'd0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
  end

  assign digit0 = d0_q;
  assign digit1 = d1_q;

endmodule

`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
// ---------------------------------------------------------------------------
// breakout_game_ctrl : score/lives/bricks bookkeeping and attract-serve-play flow
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module breakout_game_ctrl
  import breakout_game_ctrl_pkg::*;
#(
  parameter int LIVES_INIT      = 3,
  parameter int BRICK_COUNT     = BRICK_COUNT_DEF,
  parameter int SERVE_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       brick_hit,
  input  logic       ball_miss,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] lives,
  output logic [2:0] state,
  output logic       ball_hold,
  output logic       play_en,
  output logic       refill
);

  localparam int BW = $clog2(BRICK_COUNT + 1);
  localparam logic [BW-1:0]      C_BRICKS   = BW'(BRICK_COUNT);
  localparam logic [3:0]         C_LIVES    = 4'(LIVES_INIT);
  localparam logic [TIMER_W-1:0] C_SERVE    = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] C_GAMEOVER = TIMER_W'(GAMEOVER_FRAMES);

  logic vsync_q, hit_q, miss_q;
  logic frame_tick, hit_ev, miss_ev;

  game_state_e        state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [BW-1:0]      bricks_left_q, bricks_left_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ball_hold_q, ball_hold_d;
  logic               play_en_q, play_en_d;
  logic               refill_q, refill_d;
  logic               score_clr, score_inc;

  assign frame_tick = vsync & ~vsync_q;
  assign hit_ev     = brick_hit & ~hit_q;
  assign miss_ev    = ball_miss & ~miss_q;

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    bricks_left_d = bricks_left_q;
    timer_d       = timer_q;
    refill_d      = 1'b0;
    score_clr     = 1'b0;
    score_inc     = 1'b0;

    case (state_q)
      ST_ATTRACT, ST_GAMEOVER: begin
        if (start) begin
          score_clr     = 1'b1;
          lives_d       = C_LIVES;
          bricks_left_d = C_BRICKS;
          refill_d      = 1'b1;
          timer_d       = C_SERVE;
          state_d       = ST_SERVE;
        end else if (state_q == ST_GAMEOVER && frame_tick) begin
          if (timer_q <= TIMER_W'(1)) begin
            timer_d = '0;
            state_d = ST_ATTRACT;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          if (timer_q <= TIMER_W'(1)) begin
            timer_d = '0;
            state_d = ST_PLAY;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (hit_ev) begin
          score_inc = 1'b1;
          if (bricks_left_q <= BW'(1)) begin
            refill_d      = 1'b1;
            bricks_left_d = C_BRICKS;
            timer_d       = C_SERVE;
            state_d       = ST_SERVE;
          end else begin
            bricks_left_d = bricks_left_q - BW'(1);
          end
        end
        // A simultaneous miss overrides the level-clear destination.
        if (miss_ev) begin
          if (lives_q != 4'd0) begin
            lives_d = lives_q - 4'd1;
          end
          if (lives_q <= 4'd1) begin
            timer_d = C_GAMEOVER;
            state_d = ST_GAMEOVER;
          end else begin
            timer_d = C_SERVE;
            state_d = ST_SERVE;
          end
        end
      end

      default: begin
        state_d = ST_ATTRACT;
      end
    endcase

    ball_hold_d = (state_d != ST_PLAY);
    play_en_d   = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      state_q       <= ST_ATTRACT;
      lives_q       <= C_LIVES;
      bricks_left_q <= C_BRICKS;
      timer_q       <= '0;
      ball_hold_q   <= 1'b1;
      play_en_q     <= 1'b0;
      refill_q      <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      hit_q         <= brick_hit;
      miss_q        <= ball_miss;
      state_q       <= state_d;
      lives_q       <= lives_d;
      bricks_left_q <= bricks_left_d;
      timer_q       <= timer_d;
      ball_hold_q   <= ball_hold_d;
      play_en_q     <= play_en_d;
      refill_q      <= refill_d;
    end
  end

  bcd_score_counter u_score (
    .clk    (clk),
    .reset  (reset),
    .clr    (score_clr),
    .inc    (score_inc),
    .digit0 (score0),
    .digit1 (score1)
  );

  assign lives     = lives_q;
  assign state     = state_q;
  assign ball_hold = ball_hold_q;
  assign play_en   = play_en_q;
  assign refill    = refill_q;

endmodule

`default_nettype wire
